rx_frame_reader: RTL and testbench
==================================

# rx_frame_reader

Drains received Ethernet frames out of the 4096×8 receive frame buffer through its second RAM port and presents them as a byte stream with a valid/ready handshake. It sits between the RX frame buffer, which the receive MAC fills through the other port, and downstream consumers such as the header parser or the UDP payload sink. Frames are described by a start address and a byte length. Reads wrap modulo 4096, and the reader absorbs the RAM's one-cycle registered read latency under backpressure without losing or duplicating bytes.

## Interface
- ADDR_W, 12, buffer address width (depth 2^ADDR_W)
- DATA_W, 8, byte width
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to read one frame; ignored while busy=1
- start_addr  in  ADDR_W  address of the frame's first byte
- frame_len  in  ADDR_W  number of bytes to read (0..4095)
- ram_addr  out  ADDR_W  read address to the buffer port (port write-enable/data tied low at top level)
- ram_q  in  DATA_W  registered RAM output; reflects ram_addr from the previous cycle
- out_data  out  DATA_W  stream byte
- out_valid  out  1  out_data valid
- out_last  out  1  marks the final byte of the frame; qualified by out_valid
- out_ready  in  1  downstream accepts the byte when out_valid&out_ready
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- rd_ptr  out  ADDR_W  address one past the last accepted byte (buffer free pointer)

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: when start=1 and busy=0, latch rd_addr=start_addr and remaining=frame_len.
  - If frame_len=0: go to DONE, emit no bytes.
  - Otherwise go to STREAM.
- STREAM issue rule: a read is issued when remaining_issue>0 and (fifo_count + inflight − pop) < 2.
  - Issue means ram_addr=rd_addr this cycle, rd_addr increments by 1 modulo 2^ADDR_W (natural wrap 4095→0), remaining_issue decrements.
  - When no read is issued, ram_addr holds its value; the byte returned by a non-issued cycle is discarded.
- inflight is 1 in the cycle after an issue. The returned ram_q is pushed into a 2-entry output FIFO.
- FIFO head drives out_data and out_valid. out_last=1 when the head is the frame's final byte, tracked by an accepted-byte counter.
- Each accept (out_valid&out_ready) advances rd_ptr by 1 mod 2^ADDR_W.
- When the last byte is accepted: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then IDLE.
- The FIFO never overflows, and no byte is dropped or repeated under any out_ready pattern.
- start asserted during STREAM or DONE is ignored, with no latching and no queueing.
- rst mid-frame: state→IDLE, FIFO flushed, any in-flight read discarded, all counters cleared.

## Timing
- Reset values: ram_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, rd_ptr=0.
- busy=1 from the cycle after start is sampled through the cycle done is high.
- With start sampled at edge N and out_ready held high:
  - Edge N+1 onward: ram_addr=start_addr.
  - Edge N+2: ram_q holds byte 0 and is pushed.
  - Edge N+3: out_valid=1 with byte 0.
  - Throughput is 1 byte/cycle thereafter.
  - The last byte of an L-byte frame appears at edge N+L+2 with out_last=1.
  - done is high at edge N+L+3.
- A new start is accepted at the edge after done, so minimum frame-to-frame spacing is L+4 cycles.
- frame_len=0: done is high at edge N+1, busy is high only in that cycle, and out_valid stays 0.
- out_ready low: out_valid and out_data stay stable until accepted.
  - At most 2 bytes are buffered.
  - Issue resumes in the same cycle that a pop frees space, so one byte/cycle resumes with 2-cycle-latency-free restart from the FIFO.

## Test plan
- Reset, then start with start_addr=0x010, frame_len=4, buffer holding 0xA0..0xA3, out_ready=1 -> bytes A0,A1,A2,A3 on consecutive cycles, out_last on A3, done one cycle later, rd_ptr=0x014.
- Wrap: start_addr=0xFFE, frame_len=4, bytes at 0xFFE,0xFFF,0x000,0x001 = 11,22,33,44 -> stream 11,22,33,44, rd_ptr=0x002.
- Backpressure: frame_len=8, out_ready toggling 1,0,0,1,0,1… pseudo-randomly -> exactly the 8 bytes in order, out_data stable while stalled, out_last only on the 8th.
- frame_len=0 -> no out_valid, done one cycle after start, rd_ptr unchanged; start pulsed during an active 16-byte frame -> ignored, exactly 16 bytes emitted.
- Reset asserted after 3 of 10 bytes -> next cycle all outputs at reset values; a following start with frame_len=2 streams correctly from its own start_addr.

Source files
------------

// File: rtl/rx_frame_reader.sv
// rx_frame_reader: drains one frame from the RX buffer read port
// as a valid/ready byte stream through a 2-entry skid FIFO.
module rx_frame_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] frame_len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_ptr
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] acc_cnt_q;
  logic [ADDR_W-1:0] acc_addr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] hold_q;
  logic              infl_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] d0_q, d0_d;
  logic [DATA_W-1:0] d1_q, d1_d;

  logic              valid;
  logic              pop;
  logic              issue;
  logic              is_last;
  logic [2:0]        occ;

  assign valid   = (cnt_q != 2'd0);
  assign pop     = valid & out_ready;
  // occupancy the FIFO will reach once the in-flight byte lands
  assign occ     = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue   = (state_q == STREAM) && (rem_q != '0) && (occ < 3'd2);
  assign is_last = (acc_cnt_q == (len_q - 1'b1));

  assign ram_addr  = issue ? rd_addr_q : hold_q;
  assign out_data  = d0_q;
  assign out_valid = valid;
  assign out_last  = valid & is_last;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_ptr    = rd_ptr_q;

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    cnt_d = cnt_q;
    unique case ({pop, infl_q})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          d0_d = d1_q;
          d1_d = ram_q;
        end else begin
          d0_d = ram_q;
        end
      end
      2'b10: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) d0_d = ram_q;
        else d1_d = ram_q;
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      acc_addr_q <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      infl_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 2'd0;
      d0_q       <= '0;
      d1_q       <= '0;
    end else begin
      cnt_q  <= cnt_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      infl_q <= issue;
      hold_q <= ram_addr;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rd_addr_q  <= start_addr;
            rem_q      <= frame_len;
            len_q      <= frame_len;
            acc_cnt_q  <= '0;
            acc_addr_q <= start_addr;
            busy_q     <= 1'b1;
            if (frame_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            rem_q     <= rem_q - 1'b1;
          end
          if (pop) begin
            acc_cnt_q  <= acc_cnt_q + 1'b1;
            acc_addr_q <= acc_addr_q + 1'b1;
            rd_ptr_q   <= acc_addr_q + 1'b1;
            if (is_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_reader.sv
// tb_rx_frame_reader: directed frames against a RAM model,
// scoreboard of expected bytes checked on every accept.
module tb_rx_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] frame_len;
  logic [11:0] ram_addr;
  logic [7:0]  ram_q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [11:0] rd_ptr;

  logic [7:0]  mem [4096];
  logic [8:0]  sb [$];
  int          tests = 0;
  int          fails = 0;
  int          n_acc = 0;
  logic [11:0] exp_rdptr = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  rx_frame_reader #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .frame_len  (frame_len),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .rd_ptr     (rd_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_underflow observed=%0h expected=none", out_data);
        end
        if (sb.size() != 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("byte", {24'd0, out_data}, {24'd0, e[7:0]});
          chk("last", {31'd0, out_last}, {31'd0, e[8]});
        end
        n_acc++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic run_frame(input logic [11:0] a, input logic [11:0] l,
                           input bit rnd, input bit timing, input bit poke);
    int cyc;
    int fv;
    for (int i = 0; i < int'(l); i++)
      sb.push_back({(i == int'(l) - 1), mem[12'(int'(a) + i)]});
    if (l != 0) exp_rdptr = a + l;
    n_acc      = 0;
    start_addr = a;
    frame_len  = l;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    fv    = -1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && cyc < 400) begin
      if (out_valid && fv < 0) fv = cyc;
      if (poke && (cyc == 5 || cyc == 9)) begin
        start      = 1'b1;
        start_addr = 12'h555;
        frame_len  = 12'd3;
      end else begin
        start = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", {31'd0, done}, 32'd1);
    if (timing) begin
      chk("done_cycle", cyc, (l == 0) ? 32'd0 : 32'(l) + 32'd2);
      chk("first_valid", fv, (l == 0) ? -1 : 2);
    end
    chk("n_bytes", n_acc, {20'd0, l});
    chk("sb_empty", sb.size(), 32'd0);
    chk("rd_ptr", {20'd0, rd_ptr}, {20'd0, exp_rdptr});
    tick();
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4; i++) mem[12'h010 + i] = 8'hA0 + 8'(i);
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    mem[12'h000] = 8'h33;
    mem[12'h001] = 8'h44;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    frame_len  = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_ptr", {20'd0, rd_ptr}, 32'd0);
    rst = 1'b0;
    tick();

    run_frame(12'h010, 12'd4, 1'b0, 1'b1, 1'b0);
    chk("rd_ptr_basic", {20'd0, rd_ptr}, 32'h014);
    run_frame(12'hFFE, 12'd4, 1'b0, 1'b1, 1'b0);
    chk("rd_ptr_wrap", {20'd0, rd_ptr}, 32'h002);
    run_frame(12'h300, 12'd8, 1'b1, 1'b0, 1'b0);
    run_frame(12'h700, 12'd0, 1'b0, 1'b1, 1'b0);
    run_frame(12'h400, 12'd16, 1'b0, 1'b1, 1'b1);
    run_frame(12'h500, 12'd24, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) sb.push_back({(i == 9), mem[12'h100 + i]});
    n_acc      = 0;
    start_addr = 12'h100;
    frame_len  = 12'd10;
    start      = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_acc < 3 && k < 50) begin
      tick();
      k++;
    end
    chk("pre_rst_bytes", n_acc, 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_rd_ptr", {20'd0, rd_ptr}, 32'd0);
    rst = 1'b0;
    sb.delete();
    exp_rdptr = '0;
    tick();
    run_frame(12'h200, 12'd2, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
